// File: rtl/simon_stream_if.sv
// simon_stream_if: 32-bit stream front end for a SIMON 128/128 cipher core.
// It collects eight upstream words (4 key words, then 4 plaintext words,
// most-significant word first). It fires a one-cycle start to the core and
// waits for done_i, giving up after TIMEOUT cycles. It then streams the
// 128-bit ciphertext downstream as four 32-bit words, most-significant first.
module simon_stream_if #(
    parameter int TIMEOUT = 127
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [127:0] k0_o,
    output logic [127:0] pt_o,
    output logic         start_o,
    input  logic         done_i,
    input  logic [127:0] ct_i,
    output logic [31:0]  out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         busy_o,
    output logic         err_o
);

    // Wide enough to hold the value TIMEOUT itself.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      in_cnt_q, in_cnt_d;
    logic [1:0]      out_cnt_q, out_cnt_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [127:0]    k0_q, k0_d;
    logic [127:0]    pt_q, pt_d;
    logic [127:0]    ct_q, ct_d;

    logic            wait_expired;
    logic [31:0]     ct_word [4];
    logic [31:0]     out_word;

    // Split the captured ciphertext into its four outgoing words, MS first.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ct_word
        assign ct_word[gi] = ct_q[127-32*gi -: 32];
    end

    // The timeout decision must still see done_i in the last allowed WAIT
    // cycle. So the abort is decided in that same cycle and flagged right away.
    assign wait_expired = (state_q == WAIT) && (wait_cnt_q == TIMEOUT_VAL) && !done_i;

    // Next-state logic: word routing, core handshake, timeout and output sequencing.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        wait_cnt_d = wait_cnt_q;
        k0_d       = k0_q;
        pt_d       = pt_q;
        ct_d       = ct_q;

        case (state_q)
            LOAD: begin
                // in_ready_o is high throughout LOAD, so valid alone is a handshake.
                if (in_valid_i) begin
                    case (in_cnt_q)
                        3'd0: k0_d[127:96] = in_data_i;
                        3'd1: k0_d[95:64]  = in_data_i;
                        3'd2: k0_d[63:32]  = in_data_i;
                        3'd3: k0_d[31:0]   = in_data_i;
                        3'd4: pt_d[127:96] = in_data_i;
                        3'd5: pt_d[95:64]  = in_data_i;
                        3'd6: pt_d[63:32]  = in_data_i;
                        default: pt_d[31:0] = in_data_i;
                    endcase
                    in_cnt_d = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'd7) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (done_i) begin
                    ct_d      = ct_i;
                    out_cnt_d = 2'd0;
                    state_d   = SEND;
                end else if (wait_cnt_q == TIMEOUT_VAL) begin
                    state_d = LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Single state register for the controller and its datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            wait_cnt_q <= '0;
            k0_q       <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            k0_q       <= k0_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
        end
    end

    // Downstream word: held at zero outside SEND so idle output is quiet.
    always_comb begin
        out_word = 32'd0;
        if (state_q == SEND) begin
            out_word = ct_word[out_cnt_q];
        end
    end

    assign in_ready_o  = (state_q == LOAD);
    assign start_o     = (state_q == START);
    assign out_valid_o = (state_q == SEND);
    assign busy_o      = (state_q != LOAD);
    assign err_o       = wait_expired;
    assign out_data_o  = out_word;
    assign k0_o        = k0_q;
    assign pt_o        = pt_q;

endmodule

// File: tb/tb_simon_stream_if.sv
// tb_simon_stream_if: directed bench for simon_stream_if.
// A behavioural stand-in for the cipher core answers start_o with a
// ciphertext. For the published SIMON 128/128 key/plaintext it returns the
// known-answer ciphertext. For any other input it returns a fixed mix of
// key and plaintext. Expected output words go into a scoreboard queue when
// a load is driven, and they are popped as the DUT emits words.
module tb_simon_stream_if;

    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] KAT_PT  = 128'h63736564_20737265_6c6c6576_61727420;
    localparam logic [127:0] KAT_CT  = 128'h49681b1e_1e54fe3f_65aa832a_f84e0bbc;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  in_data_i = '0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [127:0] k0_o;
    logic [127:0] pt_o;
    logic         start_o;
    logic         done_i = 1'b0;
    logic [127:0] ct_i = '0;
    logic [31:0]  out_data_o;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic         busy_o;
    logic         err_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0]  sb_q [$];
    logic [127:0] kc, pc, kr, pr;

    simon_stream_if #(.TIMEOUT(127)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .k0_o(k0_o), .pt_o(pt_o), .start_o(start_o),
        .done_i(done_i), .ct_i(ct_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == KAT_KEY && p == KAT_PT) return KAT_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0ff00ff0_12345678;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back input words. Returns in the START cycle.
    task automatic load8(input logic [127:0] key, input logic [127:0] pt, input bit expect_out);
        logic [127:0] ct;
        for (int w = 0; w < 8; w++) begin
            in_valid_i = 1'b1;
            in_data_i  = (w < 4) ? key[127-32*w -: 32] : pt[127-32*(w-4) -: 32];
            #1;
            check("in_ready_load", in_ready_o, 1'b1);
            tick();
        end
        in_valid_i = 1'b0;
        check("start_pulse", start_o, 1'b1);
        check("k0_assembled", k0_o, key);
        check("pt_assembled", pt_o, pt);
        check("busy_start", busy_o, 1'b1);
        if (expect_out) begin
            ct = core_fn(key, pt);
            for (int w = 0; w < 4; w++) sb_q.push_back(ct[127-32*w -: 32]);
        end
    endtask

    // Core stand-in: called in the START cycle. It answers after lat WAIT cycles.
    task automatic run_core(input int lat, input bit noise);
        kc = k0_o;
        pc = pt_o;
        tick();
        check("start_once", start_o, 1'b0);
        for (int i = 0; i < lat; i++) begin
            if (noise) begin
                in_valid_i = 1'b1;
                in_data_i  = $urandom;
            end
            #1;
            check("wait_no_ready", in_ready_o, 1'b0);
            tick();
        end
        done_i = 1'b1;
        ct_i   = core_fn(kc, pc);
        tick();
        done_i = 1'b0;
        ct_i   = rand128();
        if (!noise) in_valid_i = 1'b0;
        check("first_valid_latency", out_valid_o, 1'b1);
        check("k0_hold", k0_o, kc);
        check("pt_hold", pt_o, pc);
    endtask

    // Drain four output words, with an optional initial stall and stray inputs.
    task automatic drain(input int stall, input bit noise);
        int got = 0;
        int cyc = 0;
        while (got < 4 && cyc < 100) begin
            out_ready_i = (cyc >= stall);
            if (noise) begin
                in_valid_i = 1'b1;
                in_data_i  = $urandom;
                done_i     = (cyc == 1);
                ct_i       = rand128();
            end
            #1;
            check("send_valid", out_valid_o, 1'b1);
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL sb_underflow: observed word %h expected none", out_data_o);
            end else if (out_ready_i) begin
                check("out_word", out_data_o, sb_q.pop_front());
                got++;
            end else begin
                check("stall_hold", out_data_o, sb_q[0]);
            end
            tick();
            cyc++;
        end
        in_valid_i  = 1'b0;
        done_i      = 1'b0;
        out_ready_i = 1'b0;
        check("drain_count", got, 4);
        check("b2b_ready", in_ready_o, 1'b1);
        check("valid_drop", out_valid_o, 1'b0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_start", start_o, 1'b0);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_out_data", out_data_o, 32'd0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_k0", k0_o, 128'd0);
        check("rst_pt", pt_o, 128'd0);

        // Known-answer vector, no stall
        load8(KAT_KEY, KAT_PT, 1'b1);
        run_core(3, 1'b0);
        drain(0, 1'b0);

        // Known-answer vector, 10-cycle downstream stall, loaded back-to-back
        load8(KAT_KEY, KAT_PT, 1'b1);
        run_core(0, 1'b0);
        drain(10, 1'b0);

        // Timeout: core never answers
        kr = rand128();
        pr = rand128();
        load8(kr, pr, 1'b0);
        tick();
        for (int i = 0; i < 127; i++) begin
            check("wait_quiet", {err_o, out_valid_o, start_o}, 3'b000);
            tick();
        end
        check("err_pulse", err_o, 1'b1);
        check("timeout_no_valid", out_valid_o, 1'b0);
        tick();
        check("timeout_ready", in_ready_o, 1'b1);
        check("err_single", err_o, 1'b0);
        check("timeout_idle", busy_o, 1'b0);
        check("timeout_sb_empty", sb_q.size(), 0);

        // done_i in the very cycle the wait counter reaches TIMEOUT
        kr = rand128();
        pr = rand128();
        load8(kr, pr, 1'b1);
        kc = k0_o;
        pc = pt_o;
        tick();
        for (int i = 0; i < 127; i++) tick();
        done_i = 1'b1;
        ct_i   = core_fn(kc, pc);
        #1;
        check("edge_no_err", err_o, 1'b0);
        tick();
        done_i = 1'b0;
        check("edge_send", out_valid_o, 1'b1);
        drain(0, 1'b0);

        // Reset after 5 input words, then a fresh load
        for (int w = 0; w < 5; w++) begin
            in_valid_i = 1'b1;
            in_data_i  = $urandom;
            tick();
        end
        in_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_k0", k0_o, 128'd0);
        check("midrst_pt", pt_o, 128'd0);
        check("midrst_ready", in_ready_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_start", start_o, 1'b0);
            tick();
        end
        kr = rand128();
        pr = rand128();
        load8(kr, pr, 1'b1);
        run_core(2, 1'b0);
        drain(0, 1'b0);

        // Reset while in SEND discards the captured ciphertext
        load8(kr, pr, 1'b0);
        run_core(1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("sendrst_valid", out_valid_o, 1'b0);
        check("sendrst_data", out_data_o, 32'd0);
        check("sendrst_ready", in_ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("sendrst_quiet", {out_valid_o, start_o}, 2'b00);
            tick();
        end

        // Stray done_i in LOAD, random in_valid during WAIT/SEND, stray done_i in SEND
        done_i = 1'b1;
        ct_i   = rand128();
        tick();
        done_i = 1'b0;
        check("stray_done_busy", busy_o, 1'b0);
        check("stray_done_valid", out_valid_o, 1'b0);
        check("stray_done_ready", in_ready_o, 1'b1);
        kr = rand128();
        pr = rand128();
        load8(kr, pr, 1'b1);
        run_core(4, 1'b1);
        drain(0, 1'b1);
        check("noise_k0_kept", k0_o, kr);
        check("noise_pt_kept", pt_o, pr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simon_stream_if.md
SIMON_STREAM_IF -- requirements
Module: simon_stream_if

Interface
REQ-001 Parameter: TIMEOUT, default 127, max cycles spent in WAIT before abort.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 in_data_i  input  32  upstream word (key words, then plaintext words).
REQ-006 in_valid_i  input  1  upstream word valid.
REQ-007 in_ready_o  output  1  block accepts a word this cycle.
REQ-008 k0_o  output  128  assembled key to cipher core.
REQ-009 pt_o  output  128  assembled plaintext to cipher core.
REQ-010 start_o  output  1  one-cycle start pulse to cipher core.
REQ-011 done_i  input  1  cipher core reports ct_i valid.
REQ-012 ct_i  input  128  ciphertext from cipher core.
REQ-013 out_data_o  output  32  downstream ciphertext word.
REQ-014 out_valid_o  output  1  downstream word valid.
REQ-015 out_ready_i  input  1  downstream accepts word.
REQ-016 busy_o  output  1  high in any state other than LOAD.
REQ-017 err_o  output  1  one-cycle pulse on WAIT timeout.

Function
REQ-018 FSM states SHALL be LOAD, START, WAIT, SEND; reset state LOAD.
REQ-019 Word transfer SHALL occur only when valid and ready are both high in the same cycle; valid without ready is ignored and changes nothing.
REQ-020 in_ready_o SHALL be high exactly when state is LOAD.
REQ-021 A 3-bit input counter SHALL route accepted words: 0..3 to k0_o[127:96], [95:64], [63:32], [31:0]; 4..7 to pt_o in the same MS-first order.
REQ-022 On the 8th accepted word, the FSM SHALL go to START; the counter wraps to 0.
REQ-023 START SHALL last exactly one cycle with start_o=1, then go to WAIT; start_o is 0 in all other states.
REQ-024 k0_o and pt_o SHALL hold stable from START until the next word is accepted in LOAD.
REQ-025 In WAIT, when done_i=1, ct_i SHALL be captured into an internal 128-bit register and the FSM SHALL go to SEND next cycle.
REQ-026 done_i SHALL be ignored in LOAD, START and SEND.
REQ-027 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle; if it reaches TIMEOUT with done_i=0, err_o pulses 1 for one cycle, the FSM goes to LOAD, and no output words are produced.
REQ-028 done_i=1 in the same cycle the counter reaches TIMEOUT SHALL count as success (capture, go to SEND, no err_o).
REQ-029 In SEND, out_valid_o SHALL be 1 and out_data_o SHALL present captured ct words MS first: [127:96], [95:64], [63:32], [31:0].
REQ-030 out_data_o SHALL remain stable while out_valid_o=1 and out_ready_i=0; stalls of any length are allowed.
REQ-031 After the 4th accepted output word, the FSM SHALL go to LOAD next cycle; out_valid_o is 0 outside SEND.
REQ-032 Minimum latency: start_o high the cycle after the 8th input handshake; first out_valid_o the cycle after done_i sampled high.
REQ-033 Back-to-back: in LOAD, a new word may be accepted the cycle immediately after the last output handshake.

Reset
REQ-034 With rst_n=0 at a rising edge, the block SHALL enter LOAD and clear both word counters, wait counter, k0_o, pt_o, and the ct register to 0.
REQ-035 Outputs after reset: in_ready_o=1, start_o=0, out_valid_o=0, out_data_o=0, busy_o=0, err_o=0.
REQ-036 Reset mid-operation (any state) SHALL discard partial words and captured ciphertext; no start_o or out_valid_o follows until a fresh 8-word load.

Verification
REQ-037 Load key words 0f0e0d0c, 0b0a0908, 07060504, 03020100, plaintext 63736564, 20737265, 6c6c6576, 61727420 with real core -> one start_o pulse; output words 49681b1e, 1e54fe3f, 65aa832a, f84e0bbc in order.
REQ-038 Same load, out_ready_i held 0 for 10 cycles then 1 -> out_data_o stays 49681b1e throughout the stall; all 4 words emitted afterwards, then in_ready_o=1.
REQ-039 Core model never asserts done_i, TIMEOUT=127 -> err_o single-cycle pulse 127 cycles after entering WAIT, no out_valid_o, in_ready_o=1 next cycle.
REQ-040 rst_n=0 after 5 input words, then new 8-word load -> k0_o/pt_o reflect only new words; exactly one start_o.
REQ-041 in_valid_i=1 with random data during WAIT and SEND, plus stray done_i pulses in LOAD and SEND -> no state, counter or output change.
